// File: rtl/dm_port_arbiter_if.sv
// Signal bundle between dm_port_arbiter, its two requesters (M0, M1) and the data memory.
// The arbiter connects through 'slave'; requesters plus memory share the 'master' view.
interface dm_port_arbiter_if;
    logic        M0_Req;
    logic [31:0] M0_Addr;
    logic        M0_WE;
    logic [31:0] M0_WD;
    logic        M0_Byte;
    logic [31:0] M0_PC;
    logic        M0_Ack;
    logic [31:0] M0_RD;

    logic        M1_Req;
    logic [31:0] M1_Addr;
    logic        M1_WE;
    logic [31:0] M1_WD;
    logic        M1_Byte;
    logic [31:0] M1_PC;
    logic        M1_Ack;
    logic [31:0] M1_RD;

    logic [31:0] DM_Addr;
    logic        DM_WE;
    logic [31:0] DM_WD;
    logic        DM_Byte;
    logic [31:0] DM_PC;
    logic [31:0] DM_D;

    modport slave (
        input  M0_Req, M0_Addr, M0_WE, M0_WD, M0_Byte, M0_PC,
        output M0_Ack, M0_RD,
        input  M1_Req, M1_Addr, M1_WE, M1_WD, M1_Byte, M1_PC,
        output M1_Ack, M1_RD,
        output DM_Addr, DM_WE, DM_WD, DM_Byte, DM_PC,
        input  DM_D
    );

    modport master (
        output M0_Req, M0_Addr, M0_WE, M0_WD, M0_Byte, M0_PC,
        input  M0_Ack, M0_RD,
        output M1_Req, M1_Addr, M1_WE, M1_WD, M1_Byte, M1_PC,
        input  M1_Ack, M1_RD,
        input  DM_Addr, DM_WE, DM_WD, DM_Byte, DM_PC,
        output DM_D
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: latch, one access, one-cycle Ack.
// Define DM_PORT_ARBITER_FIXED_PRIO_EN to give M0 fixed priority instead of round-robin.
module dm_port_arbiter #(
    parameter bit RR_INIT     = 1'b0,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    dm_port_arbiter_if.slave       bus,
    output logic                   Busy,
    output logic                   Owner,
    output logic                   Err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_owner;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wd;
    logic        r_byte;
    logic [31:0] r_pc;
    logic [31:0] r_rd0;
    logic [31:0] r_rd1;

    logic        w_any_req;
    logic        w_grant;
    logic        w_misaligned;
    logic [31:0] w_rd_capture;

    assign w_any_req = bus.M0_Req | bus.M1_Req;

`ifdef DM_PORT_ARBITER_FIXED_PRIO_EN
    assign w_grant = ~bus.M0_Req;
`else
    logic r_rr;

    // Contention goes to r_rr; a lone requester wins outright.
    assign w_grant = (bus.M0_Req & bus.M1_Req) ? r_rr : bus.M1_Req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_rr <= RR_INIT;
        else if (r_state == S_DONE)
            r_rr <= ~r_owner;
    end
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: w_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_SERVE;
            S_SERVE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wd    <= '0;
            r_byte  <= 1'b0;
            r_pc    <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_owner <= w_grant;
            r_addr  <= w_grant ? bus.M1_Addr : bus.M0_Addr;
            r_we    <= w_grant ? bus.M1_WE   : bus.M0_WE;
            r_wd    <= w_grant ? bus.M1_WD   : bus.M0_WD;
            r_byte  <= w_grant ? bus.M1_Byte : bus.M0_Byte;
            r_pc    <= w_grant ? bus.M1_PC   : bus.M0_PC;
        end
    end

    assign w_misaligned = ALIGN_CHECK && !r_byte && (r_addr[1:0] != 2'b00);
    assign w_rd_capture = (r_we || w_misaligned) ? 32'h0 : bus.DM_D;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rd0 <= '0;
            r_rd1 <= '0;
        end else if (r_state == S_SERVE) begin
            if (r_owner)
                r_rd1 <= w_rd_capture;
            else
                r_rd0 <= w_rd_capture;
        end
    end

    // DM_WE is decoded from the async-reset state, so Reset kills a pending write at once.
    assign bus.DM_Addr = r_addr;
    assign bus.DM_WE   = (r_state == S_SERVE) && r_we && !w_misaligned;
    assign bus.DM_WD   = r_wd;
    assign bus.DM_Byte = r_byte;
    assign bus.DM_PC   = r_pc;

    assign bus.M0_Ack  = (r_state == S_DONE) && !r_owner;
    assign bus.M1_Ack  = (r_state == S_DONE) &&  r_owner;
    assign bus.M0_RD   = r_rd0;
    assign bus.M1_RD   = r_rd1;

    assign Busy  = (r_state != S_IDLE);
    assign Owner = r_owner;
    assign Err   = (r_state == S_DONE) && w_misaligned;

endmodule
